// File: rtl/output_collector_pkg.sv
// Shared sizing defaults for the output collector and the argmax stage.
// Keeping them in one place means the two blocks cannot disagree on frame shape.
package output_collector_pkg;

  localparam int NUM_OUTPUT     = 10;
  localparam int DATA_WIDTH     = 16;
  localparam int TIMEOUT_CYCLES = 256;

  // Idle counter width; a disabled timer still gets one bit
  function automatic int idle_cnt_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/output_collector_idle_timer.sv
// Idle timer for a partial frame: counts stalled cycles, flags expiry.
// Ports: clk, rst (async active-low), clr, run, expire (combinational).
module output_collector_idle_timer
  import output_collector_pkg::*;
#(
  parameter int timeoutCycles = TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int CW = idle_cnt_width(timeoutCycles);

  generate
    if (timeoutCycles == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, rst, clr, run};
      assign expire    = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(timeoutCycles - 1);
      logic [CW-1:0] cnt;

      // A capture in the expiry cycle (clr) wins
      assign expire = run & ~clr & (cnt == LAST);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt <= '0;
        end else if (clr || expire) begin
          cnt <= '0;
        end else if (run) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/output_collector.sv
// Collects per-neuron outputs into one packed frame for the argmax stage.
// Ports: din/din_vld in; dout/dout_vld/frame_cnt/pending/err_dup/err_timeout out.
module output_collector
  import output_collector_pkg::*;
#(
  parameter int numInput      = NUM_OUTPUT,
  parameter int inputWidth    = DATA_WIDTH,
  parameter int timeoutCycles = TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numInput*inputWidth-1:0] din,
  input  logic [numInput-1:0]            din_vld,
  output logic [numInput*inputWidth-1:0] dout,
  output logic                           dout_vld,
  output logic [31:0]                    frame_cnt,
  output logic [numInput-1:0]            pending,
  output logic                           err_dup,
  output logic                           err_timeout
);

  localparam int DW = numInput * inputWidth;

  logic [numInput-1:0] new_v;
  logic [numInput-1:0] dup_v;
  logic [numInput-1:0] merged;
  logic [DW-1:0]       cap;
  logic [DW-1:0]       merged_data;
  logic                done;
  logic                capture;
  logic                expire;

  assign new_v   = din_vld & ~pending;
  assign dup_v   = din_vld & pending;
  assign merged  = pending | new_v;
  assign done    = &merged;
  assign capture = |new_v;

  // First value wins: only fresh slices overwrite the capture array
  always_comb begin
    merged_data = cap;
    for (int i = 0; i < numInput; i++) begin
      if (new_v[i]) begin
        merged_data[i*inputWidth +: inputWidth] =
          din[i*inputWidth +: inputWidth];
      end
    end
  end

  output_collector_idle_timer #(
    .timeoutCycles(timeoutCycles)
  ) u_idle_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (capture | ~(|pending)),
    .run   (|pending),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap     <= '0;
      pending <= '0;
    end else begin
      cap <= merged_data;
      if (done || expire) begin
        pending <= '0;
      end else begin
        pending <= merged;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout      <= '0;
      dout_vld  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      dout_vld <= done;
      if (done) begin
        dout      <= merged_data;
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_dup     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_dup     <= err_dup | (|dup_v);
      err_timeout <= expire;
    end
  end

endmodule
